// File: rtl/seg_display_ctrl.sv
// Binary-to-7-segment display controller: accepts a 14-bit sample at a rate-limited handshake,
// converts it to five BCD digits by shift-add-3 over 14 cycles, then updates the segment outputs.
module seg_display_ctrl #(
  parameter int UPDATE_DIV = 50000000,
  parameter bit BLANK_LZ   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [13:0] in_data,
  output logic        in_ready,
  output logic        busy,
  output logic        done,
  output logic [6:0]  d0,
  output logic [6:0]  d1,
  output logic [6:0]  d2,
  output logic [6:0]  d3,
  output logic [6:0]  d4
);

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

  // A full conversion occupies 16 edges, so shorter periods are stretched to that.
  localparam int         PERIOD     = (UPDATE_DIV < 16) ? 16 : UPDATE_DIV;
  localparam logic [25:0] HOLD_LOAD = 26'(PERIOD - 1);
  localparam logic [6:0] SEG_ZERO   = 7'h40;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [6:0] SEG_RST_HI = BLANK_LZ ? SEG_BLANK : SEG_ZERO;

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return ~s;
  endfunction

  state_t           state_q, state_d;
  logic [13:0]      shift_q, shift_d;
  logic [19:0]      bcd_q, bcd_d;
  logic [3:0]       step_q, step_d;
  logic [25:0]      hold_q, hold_d;
  logic             done_q, done_d;
  logic [4:0][6:0]  seg_q, seg_d;

  logic [19:0]      bcd_adj;
  logic [33:0]      shifted;
  logic [4:0][6:0]  seg_upd;
  logic             lead_nz;

  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < 5; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  assign shifted = {bcd_adj, shift_q} << 1;

  // Scan from the most significant digit so blanking stops at the first nonzero digit.
  always_comb begin
    seg_upd = '0;
    lead_nz = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      lead_nz    = lead_nz | (bcd_q[4*k +: 4] != 4'd0);
      seg_upd[k] = (BLANK_LZ && !lead_nz) ? SEG_BLANK : seg_code(bcd_q[4*k +: 4]);
    end
    seg_upd[0] = seg_code(bcd_q[3:0]);
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    step_d  = step_q;
    seg_d   = seg_q;
    done_d  = 1'b0;
    hold_d  = (hold_q != 26'd0) ? hold_q - 26'd1 : 26'd0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          shift_d = in_data;
          bcd_d   = '0;
          step_d  = '0;
          hold_d  = HOLD_LOAD;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        bcd_d   = shifted[33:14];
        shift_d = shifted[13:0];
        step_d  = step_q + 4'd1;
        if (step_q == 4'd13) state_d = UPDATE;
      end
      UPDATE: begin
        seg_d   = seg_upd;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      step_q  <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
      seg_q   <= {SEG_RST_HI, SEG_RST_HI, SEG_RST_HI, SEG_RST_HI, SEG_ZERO};
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      step_q  <= step_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      seg_q   <= seg_d;
    end
  end

  assign in_ready = (state_q == IDLE) && (hold_q == 26'd0);
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign d0       = seg_q[0];
  assign d1       = seg_q[1];
  assign d2       = seg_q[2];
  assign d3       = seg_q[3];
  assign d4       = seg_q[4];

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Bench for seg_display_ctrl: two instances (different holdoff and blanking) share one stimulus
// stream and are checked every cycle against a decimal-arithmetic reference model.
module tb_seg_display_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [13:0] in_data = '0;
  logic        rdy [2];
  logic        bsy [2];
  logic        dn  [2];
  logic [6:0]  dseg [2][5];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  localparam int PER [2] = '{20, 16};
  localparam bit BLK [2] = '{1'b1, 1'b0};

  always #5 clk = ~clk;

  seg_display_ctrl #(.UPDATE_DIV(20), .BLANK_LZ(1'b1)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[0]), .busy(bsy[0]), .done(dn[0]),
    .d0(dseg[0][0]), .d1(dseg[0][1]), .d2(dseg[0][2]), .d3(dseg[0][3]), .d4(dseg[0][4]));

  seg_display_ctrl #(.UPDATE_DIV(4), .BLANK_LZ(1'b0)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[1]), .busy(bsy[1]), .done(dn[1]),
    .d0(dseg[1][0]), .d1(dseg[1][1]), .d2(dseg[1][2]), .d3(dseg[1][3]), .d4(dseg[1][4]));

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, idx, act, exp, $time);
    end
  endtask

  // Reference model: decimal digits by division, blanking by magnitude comparison.
  function automatic logic [6:0] seg_of(input int v, input int k, input bit blk);
    logic [6:0] tbl [10];
    int p10 [5];
    int dig;
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    p10 = '{1, 10, 100, 1000, 10000};
    dig = (v / p10[k]) % 10;
    if (blk && k > 0 && v < p10[k]) return 7'h7F;
    return ~tbl[dig];
  endfunction

  bit         have  [2];
  int         since [2];
  int         pend  [2];
  logic [6:0] mdisp [2][5];

  function automatic bit m_ready(input int i);
    return !have[i] || (since[i] >= PER[i] - 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        have[i]  <= 1'b0;
        since[i] <= 0;
        pend[i]  <= 0;
        for (int k = 0; k < 5; k++)
          mdisp[i][k] <= (k == 0 || !BLK[i]) ? 7'h40 : 7'h7F;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (in_valid && m_ready(i)) begin
          have[i]  <= 1'b1;
          since[i] <= 0;
          pend[i]  <= int'(in_data);
        end else begin
          if (since[i] < 100000) since[i] <= since[i] + 1;
          if (have[i] && since[i] == 14)
            for (int k = 0; k < 5; k++) mdisp[i][k] <= seg_of(pend[i], k, BLK[i]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      for (int i = 0; i < 2; i++) begin
        chk("in_ready", i, int'(rdy[i]), int'(m_ready(i)));
        chk("busy", i, int'(bsy[i]), int'(have[i] && since[i] <= 14));
        chk("done", i, int'(dn[i]), int'(have[i] && since[i] == 15));
        for (int k = 0; k < 5; k++)
          chk("digit", i * 10 + k, int'(dseg[i][k]), int'(mdisp[i][k]));
      end
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [13:0] v);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_digits(input int i, input logic [6:0] e4, input logic [6:0] e3,
                               input logic [6:0] e2, input logic [6:0] e1, input logic [6:0] e0);
    chk("lit_done", i, int'(dn[i]), 1);
    chk("lit_d4", i, int'(dseg[i][4]), int'(e4));
    chk("lit_d3", i, int'(dseg[i][3]), int'(e3));
    chk("lit_d2", i, int'(dseg[i][2]), int'(e2));
    chk("lit_d1", i, int'(dseg[i][1]), int'(e1));
    chk("lit_d0", i, int'(dseg[i][0]), int'(e0));
  endtask

  task automatic expect_reset_state();
    chk("rst_busy", 0, int'(bsy[0]), 0);
    chk("rst_done", 0, int'(dn[0]), 0);
    chk("rst_busy", 1, int'(bsy[1]), 0);
    chk("rst_done", 1, int'(dn[1]), 0);
    chk("rst_d0", 0, int'(dseg[0][0]), 'h40);
    chk("rst_d4", 0, int'(dseg[0][4]), 'h7F);
    chk("rst_d1", 0, int'(dseg[0][1]), 'h7F);
    chk("rst_d0", 1, int'(dseg[1][0]), 'h40);
    chk("rst_d4", 1, int'(dseg[1][4]), 'h40);
    chk("rst_d1", 1, int'(dseg[1][1]), 'h40);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    expect_reset_state();
    rst = 1'b0;
    #1;
    chk("rdy_after_rst", 0, int'(rdy[0]), 1);
    chk("rdy_after_rst", 1, int'(rdy[1]), 1);
    chk_en = 1'b1;

    idle(5);
    send(14'd0);
    repeat (15) @(negedge clk);
    expect_digits(0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40);
    expect_digits(1, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40);

    idle(25);
    send(14'd16383);
    repeat (15) @(negedge clk);
    expect_digits(0, 7'h79, 7'h02, 7'h30, 7'h00, 7'h30);
    expect_digits(1, 7'h79, 7'h02, 7'h30, 7'h00, 7'h30);

    idle(25);
    send(14'd40);
    repeat (15) @(negedge clk);
    expect_digits(0, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h40);
    expect_digits(1, 7'h40, 7'h40, 7'h40, 7'h19, 7'h40);

    idle(25);
    send(14'd1005);
    repeat (15) @(negedge clk);
    expect_digits(0, 7'h7F, 7'h79, 7'h40, 7'h40, 7'h12);
    expect_digits(1, 7'h40, 7'h79, 7'h40, 7'h40, 7'h12);

    // Abort a conversion part way through with reset.
    idle(25);
    send(14'd16383);
    repeat (6) @(negedge clk);
    #1 rst = 1'b1;
    #1 expect_reset_state();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rdy_after_rst", 0, int'(rdy[0]), 1);
    chk("rdy_after_rst", 1, int'(rdy[1]), 1);
    idle(25);
    send(14'd12345);
    repeat (15) @(negedge clk);
    expect_digits(0, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12);
    expect_digits(1, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12);

    // in_valid held high with changing data exercises the holdoff period.
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 14'($urandom_range(0, 16383));
    end

    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       in_data = 14'd0;
        1:       in_data = 14'd16383;
        2:       in_data = 14'($urandom_range(0, 99));
        default: in_data = 14'($urandom_range(0, 16383));
      endcase
    end

    idle(30);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_display_ctrl.md
SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 Parameter UPDATE_DIV, default 50000000, minimum clock cycles between successive accepted samples (display refresh holdoff); legal range 16..2^26-1.
REQ-002 Parameter BLANK_LZ, default 1, 1 = blank leading zero digits on d1..d4, 0 = show all zeros.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  sample present on in_data.
REQ-006 in_data  input  14  unsigned binary sample (0..16383).
REQ-007 in_ready  output  1  block will accept a sample this cycle.
REQ-008 busy  output  1  conversion in progress.
REQ-009 done  output  1  one-cycle pulse, new digits valid on d0..d4.
REQ-010 d0..d4  output  7 each  active-low 7-segment codes, bit order gfedcba; d0 = units, d4 = ten-thousands.

Function
REQ-011 FSM states IDLE, CONVERT, UPDATE; reset state IDLE.
REQ-012 in_ready SHALL equal (state==IDLE) && (holdoff==0); handshake = in_valid && in_ready at a rising edge.
REQ-013 At handshake: in_data captured into 14-bit shift register, 20-bit BCD register cleared, step counter = 0, holdoff loaded with UPDATE_DIV-1, state -> CONVERT.
REQ-014 in_data/in_valid SHALL be ignored when no handshake occurs; no input buffering.
REQ-015 CONVERT: each cycle, every BCD nibble >= 5 gets +3, then {bcd,shift} shifted left 1; exactly 14 cycles, then -> UPDATE.
REQ-016 UPDATE: one cycle; d0..d4 registered from BCD nibbles via segment table, done asserted for exactly this edge's following cycle, state -> IDLE.
REQ-017 Latency: handshake at edge E0 -> d0..d4 and done change at edge E15.
REQ-018 busy SHALL be high in CONVERT and UPDATE, low in IDLE.
REQ-019 Segment table (active-high, before inversion): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; outputs are bitwise inverse.
REQ-020 BLANK_LZ=1: digit k (k>=1) SHALL output 7'h7F when it and all higher digits are zero; d0 never blanked.
REQ-021 holdoff decrements by 1 each cycle while nonzero, saturating at 0, in every state.
REQ-022 Effective accept period = max(UPDATE_DIV, 16) cycles; in_ready never high outside IDLE.
REQ-023 d0..d4 SHALL hold their value between UPDATE cycles; no intermediate values visible.
REQ-024 BCD nibbles SHALL never exceed 9; 16383 is the largest input and fits 5 digits.

Reset
REQ-025 rst high SHALL immediately force state IDLE, holdoff 0, busy 0, done 0, in_ready 1 (once rst low), shift/BCD registers 0.
REQ-026 Reset outputs: d0 = 7'h40; d1..d4 = 7'h7F if BLANK_LZ=1, else 7'h40.
REQ-027 rst asserted mid-CONVERT SHALL abort the conversion with no done pulse and no output update.

Verification
REQ-028 BLANK_LZ=1, in_data=0 accepted at E0 -> at E15 done=1 one cycle, d0=40, d1..d4=7F.
REQ-029 in_data=16383 -> d4..d0 = 79,02,30,00,30; busy high E1..E15 exactly.
REQ-030 BLANK_LZ=0, in_data=1005 -> d4=40, d3=79, d2=40, d1=40, d0=12.
REQ-031 BLANK_LZ=1, in_data=40 -> d0=40, d1=19, d2..d4=7F.
REQ-032 UPDATE_DIV=20, in_valid held high with changing data -> handshakes exactly 20 cycles apart; UPDATE_DIV=4 -> exactly 16 apart.
REQ-033 rst pulsed 7 cycles after handshake of 16383 -> no done, outputs at reset values, in_ready high first cycle after rst release, next sample converts correctly.
